// File: rtl/top_level_pkg.sv
// -----------------------------------------------------------------------------
// top_level_pkg
//   Shared definitions for the Hamming(16,11) SECDED encoder engine:
//   default memory map, sequencer state encoding and the combinational
//   encoder function used by the datapath.
// -----------------------------------------------------------------------------
package top_level_pkg;

  localparam int NUM_MSG_DEF   = 15;   // messages processed per run
  localparam int IN_BASE_DEF   = 0;    // byte address of message 0
  localparam int OUT_BASE_DEF  = 30;   // byte address of codeword 0
  localparam int MEM_DEPTH_DEF = 256;  // bytes in the data memory

  // Sequencer states. Each message takes exactly one pass through
  // RD_LO -> RD_HI -> WR_LO -> WR_HI.
  typedef enum logic [2:0] {
    RD_LO = 3'd0,
    RD_HI = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Hamming(16,11) SECDED encoder. Bit k-1 of d carries data bit dk.
  // Layout: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}, so bits 15..1
  // follow the classic Hamming(15,11) positions and bit 0 is the overall
  // parity that extends single-error correction to double-error detection.
  function automatic logic [15:0] hamming_enc(input logic [10:0] d);
    logic [11:1] m;
    logic        p8, p4, p2, p1, p0;
    m  = d;
    p8 = ^m[11:5];
    p4 = m[11] ^ m[10] ^ m[9] ^ m[8] ^ m[4] ^ m[3] ^ m[2];
    p2 = m[11] ^ m[10] ^ m[7] ^ m[6] ^ m[4] ^ m[3] ^ m[1];
    p1 = m[11] ^ m[9]  ^ m[7] ^ m[5] ^ m[4] ^ m[2] ^ m[1];
    p0 = (^m) ^ p8 ^ p4 ^ p2 ^ p1;
    return {m[11:5], p8, m[4:2], p4, m[1], p2, p1, p0};
  endfunction

endpackage : top_level_pkg

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//   Byte-wide single-port-write / single-port-read memory.
//   Read is combinational; write happens on the rising clock edge.
//
//   Ports:
//     clk    in   system clock
//     we     in   write enable (sampled on rising edge)
//     waddr  in   write byte address
//     wdata  in   write data byte
//     raddr  in   read byte address
//     rdata  out  read data byte (combinational from raddr)
// -----------------------------------------------------------------------------
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] core [DEPTH];

  assign rdata = core[raddr];

  // NOTE: the array has no reset on purpose: contents loaded before reset
  // must survive it, and a reset port would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

endmodule : data_mem

// File: rtl/top_level.sv
// -----------------------------------------------------------------------------
// top_level
//   Self-contained Hamming(16,11) SECDED encoder engine. After reset it
//   reads NUM_MSG eleven-bit messages (two bytes each) from its private data
//   memory dm1, encodes each one and writes the 16-bit codeword back (low
//   byte first) into the output region. When the last codeword byte is
//   written, done rises and stays high until the next reset.
//
//   Ports:
//     clk    in   system clock, all state changes on the rising edge
//     reset  in   synchronous, active-high; restarts from message 0
//     done   out  high once all NUM_MSG codewords are written
// -----------------------------------------------------------------------------
module top_level
  import top_level_pkg::*;
#(
  parameter int NUM_MSG   = NUM_MSG_DEF,
  parameter int IN_BASE   = IN_BASE_DEF,
  parameter int OUT_BASE  = OUT_BASE_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic done
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [7:0]    lo_q;          // latched d[8:1]
  logic [2:0]    hi_q;          // latched d[11:9]; upper byte bits dropped
  logic          done_nxt;

  logic          lo_en, hi_en;
  logic          wr_en;
  logic          byte_sel;      // 0 = low byte of the pair, 1 = high byte
  logic [AW-1:0] msg_ofs;
  logic [AW-1:0] raddr, waddr;
  logic [7:0]    rdata, wdata;
  logic [15:0]   codeword;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD_LO;
      idx   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
      if (lo_en) lo_q <= rdata;
      if (hi_en) hi_q <= rdata[2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = done;
    lo_en     = 1'b0;
    hi_en     = 1'b0;
    wr_en     = 1'b0;
    byte_sel  = 1'b0;

    unique case (state)
      RD_LO: begin
        lo_en     = 1'b1;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        hi_en     = 1'b1;
        byte_sel  = 1'b1;
        state_nxt = WR_LO;
      end
      WR_LO: begin
        wr_en     = 1'b1;
        state_nxt = WR_HI;
      end
      WR_HI: begin
        wr_en    = 1'b1;
        byte_sel = 1'b1;
        if (idx == 4'(NUM_MSG - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = RD_LO;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        // Unused encodings recover to the start of a run.
        state_nxt = RD_LO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: addresses and codeword
  // ---------------------------------------------------------------------------
  assign msg_ofs  = AW'({idx, 1'b0});
  assign raddr    = AW'(IN_BASE)  + msg_ofs + AW'(byte_sel);
  assign waddr    = AW'(OUT_BASE) + msg_ofs + AW'(byte_sel);
  assign codeword = hamming_enc({hi_q, lo_q});
  assign wdata    = byte_sel ? codeword[15:8] : codeword[7:0];

  // A reset edge aborts the run at once, including a write that was
  // about to land in the same cycle.
  data_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) dm1 (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule : top_level

// File: tb/tb_top_level.sv
// -----------------------------------------------------------------------------
// tb_top_level
//   Self-checking bench for the Hamming(16,11) encoder engine. Messages are
//   preloaded into dut.dm1.core; expected codeword writes go into a queue
//   and are matched in order against the memory write port; the full memory
//   image is checked after every run.
// -----------------------------------------------------------------------------
module tb_top_level;

  localparam int NMSG  = 15;
  localparam int INB   = 0;
  localparam int OUTB  = 30;
  localparam int DEPTH = 256;
  localparam int RUN_CYCLES = 4 * NMSG;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic done;

  always #5 clk = ~clk;

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    string      name;
    int         idx;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [15:0] exp_cw;
  } vec_t;

  wr_t        sb_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] img    [DEPTH];
  logic [7:0] msg_lo [NMSG];
  logic [7:0] msg_hi [NMSG];
  vec_t       vecs   [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Positional Hamming model: data bits fill the non-power-of-two
  // positions 3..15, each parity at position p covers positions with bit p.
  function automatic logic [15:0] model_cw(input logic [7:0] lo,
                                           input logic [7:0] hi);
    logic [10:0] d;
    logic [15:0] cw;
    logic        x;
    int          k;
    d  = {hi[2:0], lo};
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if ((pos & p) != 0) x ^= cw[pos];
      end
      cw[p] = x;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Expected writes and expected final output region.
  task automatic arm_scoreboard();
    logic [15:0] cw;
    sb_q.delete();
    for (int i = 0; i < NMSG; i++) begin
      cw = model_cw(msg_lo[i], msg_hi[i]);
      sb_q.push_back('{addr: 8'(OUTB + 2*i),     data: cw[7:0]});
      sb_q.push_back('{addr: 8'(OUTB + 2*i + 1), data: cw[15:8]});
      img[OUTB + 2*i]     = cw[7:0];
      img[OUTB + 2*i + 1] = cw[15:8];
    end
  endtask

  // Random background everywhere, messages in the input region.
  task automatic load_image();
    for (int a = 0; a < DEPTH; a++) img[a] = 8'($urandom);
    for (int i = 0; i < NMSG; i++) begin
      img[INB + 2*i]     = msg_lo[i];
      img[INB + 2*i + 1] = msg_hi[i];
    end
    for (int a = 0; a < DEPTH; a++) dut.dm1.core[a] = img[a];
    arm_scoreboard();
  endtask

  // One reset edge; inputs change 2 time units after the rising edge.
  task automatic apply_reset(input string name);
    reset = 1'b1;
    @(posedge clk); #2;
    check({name, "_done_in_reset"}, 32'(done), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 4 * RUN_CYCLES) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_done_latency"}, 32'(n), 32'(RUN_CYCLES));
    check({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    repeat (6) begin @(posedge clk); #2; end
    check({name, "_done_held"}, 32'(done), 32'd1);
  endtask

  task automatic check_image(input string name);
    for (int a = 0; a < DEPTH; a++)
      check($sformatf("%s_core[%0d]", name, a), 32'(dut.dm1.core[a]),
            32'(img[a]));
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (dut.dm1.we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, no write expected",
                 dut.dm1.waddr, dut.dm1.wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(dut.dm1.waddr), 32'(mon_e.addr));
        check("wr_data", 32'(dut.dm1.wdata), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{name: "all_zero", idx: 0,  lo: 8'h00, hi: 8'h00, exp_cw: 16'h0000};
    vecs[1] = '{name: "msg_7ff",  idx: 0,  lo: 8'hFF, hi: 8'h07, exp_cw: 16'hFFFF};
    vecs[2] = '{name: "msg_001",  idx: 0,  lo: 8'h01, hi: 8'h00, exp_cw: 16'h000F};
    vecs[3] = '{name: "msg14_400", idx: 14, lo: 8'h00, hi: 8'h04, exp_cw: 16'h8117};
    vecs[4] = '{name: "msg_300",  idx: 0,  lo: 8'h00, hi: 8'h03, exp_cw: 16'h6006};
    vecs[5] = '{name: "hi_junk",  idx: 0,  lo: 8'h00, hi: 8'hFB, exp_cw: 16'h6006};

    // Single-message vectors, all other messages zero.
    for (int v = 0; v < 6; v++) begin
      reset = 1'b1;
      for (int i = 0; i < NMSG; i++) begin
        msg_lo[i] = 8'h00;
        msg_hi[i] = 8'h00;
      end
      msg_lo[vecs[v].idx] = vecs[v].lo;
      msg_hi[vecs[v].idx] = vecs[v].hi;
      load_image();
      apply_reset(vecs[v].name);
      wait_done(vecs[v].name);
      check({vecs[v].name, "_cw_lo"},
            32'(dut.dm1.core[OUTB + 2*vecs[v].idx]), 32'(vecs[v].exp_cw[7:0]));
      check({vecs[v].name, "_cw_hi"},
            32'(dut.dm1.core[OUTB + 2*vecs[v].idx + 1]), 32'(vecs[v].exp_cw[15:8]));
      check_image(vecs[v].name);
    end

    // Random messages with junk in the ignored high bits; reset mid-run.
    reset = 1'b1;
    for (int i = 0; i < NMSG; i++) begin
      msg_lo[i] = 8'($urandom);
      msg_hi[i] = 8'($urandom);
    end
    load_image();
    apply_reset("rand");
    repeat (24) begin @(posedge clk); #2; end
    check("rand_done_before_abort", 32'(done), 32'd0);
    apply_reset("rand_abort");
    arm_scoreboard();
    wait_done("rand_restart");
    check_image("rand");

    // Reset while in DONE: done drops and the run repeats identically.
    apply_reset("done_rst");
    arm_scoreboard();
    wait_done("done_rst_rerun");
    check_image("done_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_top_level
